// File: rtl/session_timeout_timer.sv
// Session countdown for the ATM front end: turns the 4 Hz strobe into whole
// seconds, restarts on user activity, warns near the end and pulses on expiry.
module session_timeout_timer #(
    parameter int TICKS_PER_SEC = 4,
    parameter int TIMEOUT_SEC   = 30,
    parameter int WARN_SEC      = 10,
    parameter int SEC_W         = 6
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             start,
    input  logic             activity,
    input  logic             cancel,
    output logic [SEC_W-1:0] sec_left,
    output logic             running,
    output logic             warning,
    output logic             expired,
    output logic             timed_out
);

    localparam int               SUB_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(TIMEOUT_SEC);
    localparam logic [SEC_W-1:0] SEC_WARN = SEC_W'(WARN_SEC);
    // A session shorter than the warning window starts out already warning.
    localparam bit               LOAD_IN_WARN = (TIMEOUT_SEC <= WARN_SEC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WARN, S_TIMEOUT} state_t;

    state_t           state;
    logic [SUB_W-1:0] sub;
    logic             counting;
    logic [SEC_W-1:0] sec_dec;

    assign counting = (state == S_RUN) || (state == S_WARN);
    // Saturating decrement so sec_left can never wrap.
    assign sec_dec  = (sec_left != '0) ? sec_left - SEC_W'(1) : '0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sec_left  <= '0;
            sub       <= '0;
            running   <= 1'b0;
            warning   <= 1'b0;
            expired   <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (cancel) begin
                state     <= S_IDLE;
                sec_left  <= '0;
                sub       <= '0;
                running   <= 1'b0;
                warning   <= 1'b0;
                timed_out <= 1'b0;
            end else if (start || (activity && counting)) begin
                state     <= LOAD_IN_WARN ? S_WARN : S_RUN;
                sec_left  <= SEC_LOAD;
                sub       <= '0;
                running   <= 1'b1;
                warning   <= LOAD_IN_WARN;
                timed_out <= 1'b0;
            end else if (tick_in && counting) begin
                if (sub != SUB_MAX) begin
                    sub <= sub + SUB_W'(1);
                end else begin
                    sub      <= '0;
                    sec_left <= sec_dec;
                    if (sec_dec == '0) begin
                        state     <= S_TIMEOUT;
                        running   <= 1'b0;
                        warning   <= 1'b0;
                        expired   <= 1'b1;
                        timed_out <= 1'b1;
                    end else if (sec_dec <= SEC_WARN) begin
                        state   <= S_WARN;
                        warning <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_session_timeout_timer.sv
// Scenario bench for session_timeout_timer: directed scenarios against fixed
// expectations, then random traffic against a tick-budget reference model.
module tb_session_timeout_timer;

    localparam int TPS  = 4;
    localparam int TOUT = 3;
    localparam int WSEC = 1;
    localparam int SW   = 4;

    logic          clk_in   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          tick_in  = 1'b0;
    logic          start    = 1'b0;
    logic          activity = 1'b0;
    logic          cancel   = 1'b0;
    logic [SW-1:0] sec_left;
    logic          running, warning, expired, timed_out;

    int checks = 0;
    int errors = 0;

    // Reference model: the session is a budget of ticks; seconds shown are
    // the budget rounded up to whole seconds.
    bit m_active, m_to, m_exp;
    int m_ticks;

    session_timeout_timer #(
        .TICKS_PER_SEC(TPS), .TIMEOUT_SEC(TOUT), .WARN_SEC(WSEC), .SEC_W(SW)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .start(start),
        .activity(activity), .cancel(cancel), .sec_left(sec_left),
        .running(running), .warning(warning), .expired(expired),
        .timed_out(timed_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [SW+3:0] mk(input int s, input bit r, input bit w,
                                         input bit e, input bit t);
        return {SW'(s), r, w, e, t};
    endfunction

    function automatic logic [SW+3:0] model_vec();
        int sec;
        sec = (m_ticks + TPS - 1) / TPS;
        return {SW'(sec), m_active, (m_active && sec > 0 && sec <= WSEC), m_exp, m_to};
    endfunction

    function automatic logic [SW+3:0] dut_vec();
        return {sec_left, running, warning, expired, timed_out};
    endfunction

    task automatic model_reset();
        m_active = 0; m_to = 0; m_exp = 0; m_ticks = 0;
    endtask

    task automatic step(input bit c, input bit s, input bit a, input bit t);
        cancel = c; start = s; activity = a; tick_in = t;
        @(posedge clk_in);
        m_exp = 0;
        if (c) begin
            m_active = 0; m_to = 0; m_ticks = 0;
        end else if (s || (a && m_active)) begin
            m_active = 1; m_to = 0; m_ticks = TOUT * TPS;
        end else if (t && m_active) begin
            m_ticks--;
            if (m_ticks == 0) begin
                m_active = 0; m_to = 1; m_exp = 1;
            end
        end
        #1;
        cancel = 0; start = 0; activity = 0; tick_in = 0;
    endtask

    task automatic tick5();
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        logic [SW+3:0] got;
        #13;
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_initial got=%h exp=%h", got, mk(0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        step(0, 1, 0, 0);
        repeat (5) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(2, 1, 0, 0, 0)) begin
            errors++; $display("FAIL reset_prerun got=%h exp=%h", got, mk(2, 1, 0, 0, 0));
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_async got=%h exp=%h", got, mk(0, 0, 0, 0, 0));
        end
        #1 rst_n = 1'b1;
        repeat (5) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_idle_ticks got=%h exp=%h", got, mk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_full_timeout();
        logic [SW+3:0] got;
        step(0, 1, 0, 0);
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL tmo_start got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
        repeat (3) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL tmo_tick3 got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
        tick5();
        got = dut_vec(); checks++;
        if (got !== mk(2, 1, 0, 0, 0)) begin
            errors++; $display("FAIL tmo_tick4 got=%h exp=%h", got, mk(2, 1, 0, 0, 0));
        end
        repeat (4) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(1, 1, 1, 0, 0)) begin
            errors++; $display("FAIL tmo_tick8 got=%h exp=%h", got, mk(1, 1, 1, 0, 0));
        end
        repeat (4) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 1, 1)) begin
            errors++; $display("FAIL tmo_tick12 got=%h exp=%h", got, mk(0, 0, 0, 1, 1));
        end
        step(0, 0, 0, 0);
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL tmo_pulse_end got=%h exp=%h", got, mk(0, 0, 0, 0, 1));
        end
        tick5();
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL tmo_tick13 got=%h exp=%h", got, mk(0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_activity_reload();
        logic [SW+3:0] got;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (9) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(1, 1, 1, 0, 0)) begin
            errors++; $display("FAIL act_warn got=%h exp=%h", got, mk(1, 1, 1, 0, 0));
        end
        step(0, 0, 1, 0);
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL act_reload got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
        repeat (11) tick5();
        got = dut_vec(); checks++;
        if (got !== mk(1, 1, 1, 0, 0)) begin
            errors++; $display("FAIL act_tick11 got=%h exp=%h", got, mk(1, 1, 1, 0, 0));
        end
        tick5();
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 1, 1)) begin
            errors++; $display("FAIL act_tick12 got=%h exp=%h", got, mk(0, 0, 0, 1, 1));
        end
    endtask

    task automatic test_simultaneous();
        logic [SW+3:0] got;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL sim_start_cancel got=%h exp=%h", got, mk(0, 0, 0, 0, 0));
        end
        step(0, 1, 0, 0);
        repeat (11) tick5();
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL sim_act_tick12 got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
        step(0, 1, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL sim_start_drops_tick got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
    endtask

    task automatic test_restart();
        logic [SW+3:0] got;
        step(0, 1, 0, 0);
        repeat (12) tick5();
        step(0, 0, 1, 0);
        got = dut_vec(); checks++;
        if (got !== mk(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL rst_act_ignored got=%h exp=%h", got, mk(0, 0, 0, 0, 1));
        end
        step(0, 1, 0, 0);
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL rst_restart got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [SW+3:0] got;
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1);
        got = dut_vec(); checks++;
        if (got !== mk(3, 1, 0, 0, 0)) begin
            errors++; $display("FAIL b2b_tick3 got=%h exp=%h", got, mk(3, 1, 0, 0, 0));
        end
        step(0, 0, 0, 1);
        got = dut_vec(); checks++;
        if (got !== mk(2, 1, 0, 0, 0)) begin
            errors++; $display("FAIL b2b_tick4 got=%h exp=%h", got, mk(2, 1, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        logic [SW+3:0] got, exp;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 60));
            got = dut_vec();
            exp = model_vec();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_timeout();
        test_activity_reload();
        test_simultaneous();
        test_restart();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
